sram_1r1w_param: RTL and testbench

//  Single-clock, parametrised 1R1W memory; successor to the fixed 16x8 dual-clock SRAM model.

---
 rtl/sram_pkg.sv | 40 ++++
 rtl/sram_1r1w_array.sv | 47 ++++
 rtl/sram_1r1w_param.sv | 154 +++++++++++++++
 tb/tb_sram_1r1w_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1R1W SRAM: sweep FSM states,
// byte-lane merge and elaboration-time parameter sanity check.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_state_e;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MAX_DATA_WIDTH  = 1024;
    localparam int MAX_WMASK_WIDTH = MAX_DATA_WIDTH / 8;

    function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
        input logic [MAX_DATA_WIDTH-1:0]  old_word,
        input logic [MAX_DATA_WIDTH-1:0]  new_word,
        input logic [MAX_WMASK_WIDTH-1:0] mask
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_WMASK_WIDTH; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    function automatic bit params_ok(
        input int data_width,
        input int wmask_width,
        input int read_latency
    );
        return (data_width > 0) && (data_width % 8 == 0) &&
               (data_width <= MAX_DATA_WIDTH) &&
               (wmask_width == data_width / 8) &&
               ((read_latency == 1) || (read_latency == 2));
    endfunction

endpackage

// File: rtl/sram_1r1w_array.sv
// Storage core: plain register array with byte-masked write and a registered,
// read-first read port whose data register holds between reads.
module sram_1r1w_array
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic                   re,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]  rdata
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] write_word;

    always_comb begin
        write_word = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(mem[waddr]),
                                             MAX_DATA_WIDTH'(wdata),
                                             MAX_WMASK_WIDTH'(wmask)));
    end

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= write_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sram_1r1w_param.sv
// Single-clock parametrised 1R1W SRAM: post-reset clear sweep, byte-masked
// writes, 1- or 2-cycle read latency and optional write-first bypass.
module sram_1r1w_param
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int WMASK_WIDTH    = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk0,
    input  logic                   rst_n,
    input  logic                   csb0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_valid,
    output logic                   init_busy,
    output logic                   collision
);

    if (!params_ok(DATA_WIDTH, WMASK_WIDTH, READ_LATENCY)) begin : g_param_error
        $error("sram_1r1w_param: bad DATA_WIDTH/WMASK_WIDTH/READ_LATENCY");
    end

    sram_state_e           state;
    logic [ADDR_WIDTH-1:0] clear_addr;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state      <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            clear_addr <= '0;
            init_busy  <= (CLEAR_ON_RESET != 0);
        end else if (state == INIT) begin
            clear_addr <= clear_addr + 1'b1;
            if (clear_addr == '1) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    logic in_init;
    logic wr_fire;
    logic rd_fire;
    logic same_addr;

    assign in_init   = (state == INIT);
    assign wr_fire   = (state == RUN) && !csb0;
    assign rd_fire   = (state == RUN) && !csb1;
    assign same_addr = wr_fire && rd_fire && (addr0 == addr1);

    logic                   arr_we;
    logic [ADDR_WIDTH-1:0]  arr_waddr;
    logic [DATA_WIDTH-1:0]  arr_wdata;
    logic [WMASK_WIDTH-1:0] arr_wmask;
    logic [DATA_WIDTH-1:0]  arr_rdata;

    // The sweep borrows the write port with a full mask and zero data.
    always_comb begin
        arr_we    = rst_n && (in_init || wr_fire);
        arr_waddr = in_init ? clear_addr : addr0;
        arr_wdata = in_init ? '0 : din0;
        arr_wmask = in_init ? '1 : wmask0;
    end

    sram_1r1w_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WMASK_WIDTH(WMASK_WIDTH)
    ) u_array (
        .clk  (clk0),
        .rst_n(rst_n),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .wmask(arr_wmask),
        .re   (rd_fire),
        .raddr(addr1),
        .rdata(arr_rdata)
    );

    // First read stage. hit1/byp_* hold with the array read register so the
    // merged word stays stable while no new result is presented.
    logic                   v1;
    logic                   coll1;
    logic                   hit1;
    logic [DATA_WIDTH-1:0]  byp_data;
    logic [WMASK_WIDTH-1:0] byp_mask;
    logic [DATA_WIDTH-1:0]  s1_data;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            coll1    <= 1'b0;
            hit1     <= 1'b0;
            byp_data <= '0;
            byp_mask <= '0;
        end else begin
            v1    <= rd_fire;
            coll1 <= same_addr;
            if (rd_fire) begin
                hit1     <= same_addr;
                byp_data <= din0;
                byp_mask <= wmask0;
            end
        end
    end

    // The array reads old contents on a same-edge hit; bypass patches in the
    // enabled lanes of the concurrent write.
    always_comb begin
        s1_data = arr_rdata;
        if ((BYPASS != 0) && hit1) begin
            s1_data = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(arr_rdata),
                                              MAX_DATA_WIDTH'(byp_data),
                                              MAX_WMASK_WIDTH'(byp_mask)));
        end
    end

    if (READ_LATENCY == 2) begin : g_out_stage
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  v2;
        logic                  coll2;

        always_ff @(posedge clk0) begin
            if (!rst_n) begin
                dout_q <= '0;
                v2     <= 1'b0;
                coll2  <= 1'b0;
            end else begin
                v2    <= v1;
                coll2 <= coll1;
                if (v1) begin
                    dout_q <= s1_data;
                end
            end
        end

        assign dout1       = dout_q;
        assign dout1_valid = v2;
        assign collision   = coll2;
    end else begin : g_direct
        assign dout1       = s1_data;
        assign dout1_valid = v1;
        assign collision   = coll1;
    end

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Directed bench for sram_1r1w_param: two instances share stimulus, one with
// 1-cycle latency and bypass, one with 2-cycle latency and no bypass.
module tb_sram_1r1w_param;

    logic        clk;
    logic        rst_n;
    logic        csb0;
    logic [5:0]  addr0;
    logic [31:0] din0;
    logic [3:0]  wmask0;
    logic        csb1;
    logic [5:0]  addr1;

    logic [31:0] dout_a, dout_b;
    logic        valid_a, valid_b;
    logic        busy_a, busy_b;
    logic        coll_a, coll_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic        coll_a_q[$];
    logic        coll_b_q[$];

    sram_1r1w_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk0(clk), .rst_n(rst_n), .csb0(csb0), .addr0(addr0), .din0(din0),
        .wmask0(wmask0), .csb1(csb1), .addr1(addr1), .dout1(dout_a),
        .dout1_valid(valid_a), .init_busy(busy_a), .collision(coll_a)
    );

    sram_1r1w_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk0(clk), .rst_n(rst_n), .csb0(csb0), .addr0(addr0), .din0(din0),
        .wmask0(wmask0), .csb1(csb1), .addr1(addr1), .dout1(dout_b),
        .dout1_valid(valid_b), .init_busy(busy_b), .collision(coll_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1;
        csb1 = 1'b1;
    endtask

    // One cycle of traffic; a read pushes the per-instance expected result.
    task automatic op(input bit w, input logic [5:0] wa, input logic [31:0] wd,
                      input logic [3:0] wm, input bit r, input logic [5:0] ra,
                      input logic [31:0] ea, input logic [31:0] eb, input bit ec);
        csb0   = !w;
        addr0  = wa;
        din0   = wd;
        wmask0 = wm;
        csb1   = !r;
        addr1  = ra;
        if (r) begin
            exp_a_q.push_back(ea);
            exp_b_q.push_back(eb);
            coll_a_q.push_back(ec);
            coll_b_q.push_back(ec);
        end
        tick();
        idle();
    endtask

    // ---------------- scoreboards ----------------
    always begin
        @(posedge clk);
        #2;
        if (valid_a) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("a_dout", dout_a, exp_a_q.pop_front());
                check("a_collision", {31'd0, coll_a}, {31'd0, coll_a_q.pop_front()});
            end
        end else if (coll_a) begin
            check("a_stray_collision", 32'd1, 32'd0);
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (valid_b) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("b_dout", dout_b, exp_b_q.pop_front());
                check("b_collision", {31'd0, coll_b}, {31'd0, coll_b_q.pop_front()});
            end
        end else if (coll_b) begin
            check("b_stray_collision", 32'd1, 32'd0);
        end
    end

    // Counts cycles until init_busy of instance a drops, bounded.
    task automatic count_sweep(output int n, output int noisy);
        n = 0;
        noisy = 0;
        do begin
            tick();
            n++;
            if (valid_a || valid_b || coll_a || coll_b) noisy++;
        end while (busy_a && n < 200);
    endtask

    logic [31:0] fill_vals [4];
    logic        b2b_valid [6];

    initial begin
        int n;
        int noisy;

        fill_vals[0] = 32'h0102_0304;
        fill_vals[1] = 32'h1112_1314;
        fill_vals[2] = 32'h2122_2324;
        fill_vals[3] = 32'h3132_3334;
        b2b_valid[0] = 1'b0;
        b2b_valid[1] = 1'b1;
        b2b_valid[2] = 1'b1;
        b2b_valid[3] = 1'b1;
        b2b_valid[4] = 1'b1;
        b2b_valid[5] = 1'b0;

        rst_n  = 1'b0;
        addr0  = '0;
        addr1  = '0;
        din0   = '0;
        wmask0 = '0;
        idle();
        repeat (3) tick();

        // Reset state
        check("rst_dout_a", dout_a, 32'h0);
        check("rst_valid_a", {31'd0, valid_a}, 32'd0);
        check("rst_busy_a", {31'd0, busy_a}, 32'd1);
        check("rst_coll_a", {31'd0, coll_a}, 32'd0);
        check("rst_dout_b", dout_b, 32'h0);
        check("rst_valid_b", {31'd0, valid_b}, 32'd0);
        check("rst_busy_b", {31'd0, busy_b}, 32'd1);

        // Sweep length, with write+read requests held active throughout
        csb0   = 1'b0;
        addr0  = 6'd7;
        din0   = 32'hFFFF_FFFF;
        wmask0 = 4'hF;
        csb1   = 1'b0;
        addr1  = 6'd7;
        rst_n  = 1'b1;
        count_sweep(n, noisy);
        idle();
        check("init_cycles", n, 32'd64);
        check("init_quiet", noisy, 32'd0);
        check("init_done_b", {31'd0, busy_b}, 32'd0);

        // Every word reads zero after the sweep
        for (int i = 0; i < 64; i++) begin
            op(0, 6'd0, 32'h0, 4'h0, 1, 6'(i), 32'h0, 32'h0, 0);
        end
        repeat (3) tick();

        // Byte-masked overwrite; read on the edge after a write sees it
        op(1, 6'd5, 32'hDEAD_BEEF, 4'b1111, 0, 6'd0, 32'h0, 32'h0, 0);
        op(1, 6'd5, 32'h1122_3344, 4'b0101, 0, 6'd0, 32'h0, 32'h0, 0);
        op(0, 6'd0, 32'h0, 4'h0, 1, 6'd5, 32'hDE22_BE44, 32'hDE22_BE44, 0);
        op(1, 6'd5, 32'hFFFF_FFFF, 4'b0000, 0, 6'd0, 32'h0, 32'h0, 0);
        op(0, 6'd0, 32'h0, 4'h0, 1, 6'd5, 32'hDE22_BE44, 32'hDE22_BE44, 0);
        repeat (3) tick();

        // Back-to-back reads: valid timeline of the 2-cycle instance
        for (int i = 0; i < 4; i++) begin
            op(1, 6'(i), fill_vals[i], 4'hF, 0, 6'd0, 32'h0, 32'h0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            op(0, 6'd0, 32'h0, 4'h0, 1, 6'(i), fill_vals[i], fill_vals[i], 0);
            check($sformatf("b2b_valid_b[%0d]", i), {31'd0, valid_b}, {31'd0, b2b_valid[i]});
        end
        for (int i = 4; i < 6; i++) begin
            tick();
            check($sformatf("b2b_valid_b[%0d]", i), {31'd0, valid_b}, {31'd0, b2b_valid[i]});
        end
        tick();

        // Same-edge collision at address 9, then a non-colliding pair
        op(1, 6'd9, 32'hAAAA_AAAA, 4'hF, 0, 6'd0, 32'h0, 32'h0, 0);
        op(1, 6'd9, 32'h5555_5555, 4'b0011, 1, 6'd9, 32'hAAAA_5555, 32'hAAAA_AAAA, 1);
        op(0, 6'd0, 32'h0, 4'h0, 1, 6'd9, 32'hAAAA_5555, 32'hAAAA_5555, 0);
        op(1, 6'd10, 32'h1234_5678, 4'hF, 1, 6'd9, 32'hAAAA_5555, 32'hAAAA_5555, 0);
        op(0, 6'd0, 32'h0, 4'h0, 1, 6'd10, 32'h1234_5678, 32'h1234_5678, 0);
        repeat (3) tick();

        // Reset with a 2-cycle read in flight: it must be dropped
        csb1  = 1'b0;
        addr1 = 6'd5;
        exp_a_q.push_back(32'hDE22_BE44);
        coll_a_q.push_back(1'b0);
        tick();
        csb1  = 1'b1;
        rst_n = 1'b0;
        tick();
        check("rst_inflight_valid_b", {31'd0, valid_b}, 32'd0);
        check("rst_inflight_dout_b", dout_b, 32'h0);
        check("rst_inflight_dout_a", dout_a, 32'h0);
        check("rst_inflight_busy", {31'd0, busy_a}, 32'd1);
        tick();
        rst_n = 1'b1;

        // Reset again 20 cycles into the sweep: full sweep restarts
        repeat (20) tick();
        check("mid_sweep_busy", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_sweep(n, noisy);
        check("restart_cycles", n, 32'd64);
        check("restart_quiet", noisy, 32'd0);
        check("restart_dout_b", dout_b, 32'h0);

        // The sweep zeroed previously written words
        op(0, 6'd0, 32'h0, 4'h0, 1, 6'd9, 32'h0, 32'h0, 0);
        op(0, 6'd0, 32'h0, 4'h0, 1, 6'd5, 32'h0, 32'h0, 0);
        repeat (4) tick();

        check("a_queue_drained", exp_a_q.size(), 32'd0);
        check("b_queue_drained", exp_b_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
